aes_subshift_seq: RTL and testbench
===================================

AES_SUBSHIFT_SEQ -- requirements
Module: aes_subshift_seq

Interface
REQ-001 SHALL have parameter LANES, default 1, giving the number of aes_sbox instances used per cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_state and in_dec are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a new state.
REQ-006 SHALL have port in_dec, input, 1 bit: 0 selects SubBytes then ShiftRows; 1 selects InvShiftRows then InvSubBytes.
REQ-007 SHALL have port in_state, input, 128 bits: the AES state; byte n = in_state[127-8n -: 8], row n%4, column n/4 (FIPS-197 order).
REQ-008 SHALL have port out_valid, output, 1 bit: out_state holds a completed result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_state, output, 128 bits: the transformed state, in the same byte order as in_state.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL instantiate exactly LANES aes_sbox instances, with each instance's dec input driven from the captured mode bit.
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in_valid&in_ready at an edge captures in_state and in_dec, clears the byte counter and moves the FSM to RUN.
REQ-015 In RUN and DONE, in_ready SHALL be 0; in_valid, in_state and in_dec SHALL be ignored, and any change to them SHALL NOT affect the result.
REQ-016 In RUN, each cycle SHALL produce result bytes idx..idx+LANES-1 and then advance idx by LANES; once idx+LANES reaches 16, the FSM SHALL move to DONE.
REQ-017 For result byte at row r, column c, forward mode SHALL produce S(src[r, (c+r) mod 4]).
REQ-018 For result byte at row r, column c, inverse mode SHALL produce InvS(src[r, (c-r) mod 4]).
REQ-019 Latency: for an acceptance edge E, out_valid SHALL rise after edge E+16/LANES, i.e. 16 cycles with LANES=1.
REQ-020 In DONE, out_valid SHALL be 1 and out_state SHALL remain stable until out_valid&out_ready is seen at an edge; the FSM SHALL then return to IDLE.
REQ-021 Back-to-back operation SHALL insert one IDLE bubble cycle: no acceptance in the same cycle as the output handshake.
REQ-022 If out_ready is already 1 when DONE is entered, the handshake SHALL complete at the first DONE edge, so out_valid is high for exactly 1 cycle.
REQ-023 out_state SHALL update only on byte writes during RUN, and SHALL retain the last result in IDLE.
REQ-024 The counter SHALL be 5 bits wide and SHALL NOT wrap; the terminal compare is the idx+LANES==16 condition of REQ-016.

Reset
REQ-025 With rst_n=0 at an edge: FSM to IDLE, in_ready=1, out_valid=0, busy=0, out_state=128'h0, counter=0, captured mode=0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no output handshake, and a new acceptance SHALL be possible on the first edge after rst_n returns to 1.

Verification
REQ-027 in_state=128'h0, in_dec=0 -> out_state=128'h63636363_63636363_63636363_63636363, with out_valid after 16 cycles (LANES=1).
REQ-028 in_state=128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, in_dec=0 -> out_state=128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5.
REQ-029 in_state=128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, in_dec=1 -> out_state=128'h193de3be_a0f4e22b_9ac68d2a_e9f84808.
REQ-030 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_state -> out_state stable, in_ready=0, the second input not accepted; release out_ready -> one handshake, in_ready=1 on the next cycle.
REQ-031 Pulse rst_n=0 for 1 cycle at RUN cycle 7 -> out_valid never rises for that input; then send 128'h0 with in_dec=1 -> out_state=128'h52525252_52525252_52525252_52525252.
REQ-032 Run 1000 random states with random in_dec and random out_ready stalls, at LANES=1, 2 and 4 -> every result matches a reference model, with latency 16, 8 and 4 cycles respectively.

Source files
------------

// File: rtl/aes_subshift_seq.sv
// aes_subshift_seq: sequential AES SubBytes+ShiftRows / InvShiftRows+InvSubBytes.
// A 128-bit state is captured on an input handshake. LANES S-box instances then
// produce LANES result bytes per cycle, and the result is held until the consumer
// accepts it.
//
// Handshake rule: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready is 1 only in IDLE. out_valid is 1 only in DONE, and
// out_state is stable while out_valid is 1.
//
// Parameters:
//   LANES     - S-box instances used per cycle (1, 2 or 4)
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous active-low reset
//   in_valid  - in_state/in_dec are valid
//   in_ready  - block accepts a new state (IDLE)
//   in_dec    - 0: SubBytes then ShiftRows, 1: InvShiftRows then InvSubBytes
//   in_state  - AES state, byte n = in_state[127-8n -: 8], row n%4, column n/4
//   out_valid - out_state holds a completed result (DONE)
//   out_ready - consumer accepts the result
//   out_state - transformed state, same byte order as in_state
//   busy      - FSM is not in IDLE

module aes_sbox (
    input  logic       dec,
    input  logic [7:0] value,
    output logic [7:0] subst
);
    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254. The loop multiplies a^2, a^4, ... a^128
    // together. Zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        return rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05;
    endfunction

    assign subst = dec ? gf_inv(inv_affine(value)) : affine(gf_inv(value));
endmodule

module aes_subshift_seq #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dec,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [4:0]   idx;
    logic [127:0] cap_state;
    logic         cap_dec;

    logic [3:0]   dst_idx [LANES];
    logic [7:0]   sb_out  [LANES];

    // Each lane writes result byte idx+k. Its source byte sits in the same row r,
    // in column c+r (forward) or c-r (inverse). Both are taken mod 4 by the
    // 2-bit wraparound.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [3:0] dst;
        logic [1:0] scol;
        logic [3:0] src;
        logic [7:0] sb_in;

        assign dst   = idx[3:0] + 4'(k);
        assign scol  = cap_dec ? (dst[3:2] - dst[1:0]) : (dst[3:2] + dst[1:0]);
        assign src   = {scol, dst[1:0]};
        assign sb_in = cap_state[{4'd15 - src, 3'b000} +: 8];

        aes_sbox u_sbox (
            .dec   (cap_dec),
            .value (sb_in),
            .subst (sb_out[k])
        );

        assign dst_idx[k] = dst;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 5'd0;
            cap_state <= 128'h0;
            cap_dec   <= 1'b0;
            out_state <= 128'h0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap_state <= in_state;
                        cap_dec   <= in_dec;
                        idx       <= 5'd0;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    for (int k = 0; k < LANES; k++) begin
                        out_state[{4'd15 - dst_idx[k], 3'b000} +: 8] <= sb_out[k];
                    end
                    // The counter stops on the last group instead of wrapping.
                    if (idx + 5'(LANES) == 5'd16) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 5'(LANES);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_subshift_seq.sv
// Testbench for aes_subshift_seq. It runs three instances at the same time,
// with LANES = 1, 2 and 4. Each instance has its own stimulus signals.
// Results are compared against a reference model of SubBytes/ShiftRows. The
// model's S-box is built from exponent/log tables and the bitwise affine rule.
module tb_aes_subshift_seq;
    logic         clk = 1'b0;
    logic         rst_n_a     [3];
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic         in_dec_a    [3];
    logic [127:0] in_state_a  [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] out_state_a [3];
    logic         busy_a      [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t[256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_subshift_seq #(.LANES(1 << g)) dut (
            .clk       (clk),
            .rst_n     (rst_n_a[g]),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_dec    (in_dec_a[g]),
            .in_state  (in_state_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_state (out_state_a[g]),
            .busy      (busy_a[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Build the S-box from powers of generator 3 and their logs, then apply the
    // affine map bit by bit. The inverse table is the forward table read backwards.
    task automatic build_tables();
        logic [7:0] pw [256];
        int         lg [256];
        logic [7:0] x, inv, b, c;
        pw[0] = 8'h01;
        for (int i = 0; i < 255; i++) begin
            x = pw[i];
            pw[i+1] = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
            lg[pw[i]] = i;
        end
        c = 8'h63;
        for (int v = 0; v < 256; v++) begin
            inv = (v == 0) ? 8'h00 : pw[(255 - lg[v]) % 255];
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[v]  = b;
            isbox_t[b] = v[7:0];
        end
    endtask

    function automatic logic [127:0] ref_xform(input logic [127:0] st, input logic dec);
        logic [127:0] res;
        int r, c, src;
        res = '0;
        for (int n = 0; n < 16; n++) begin
            r = n % 4;
            c = n / 4;
            if (!dec) begin
                src = 4 * ((c + r) % 4) + r;
                res[127-8*n -: 8] = sbox_t[st[127-8*src -: 8]];
            end else begin
                src = 4 * ((c - r + 4) % 4) + r;
                res[127-8*n -: 8] = isbox_t[st[127-8*src -: 8]];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Call at #1 after an edge, with instance l in IDLE. Returns at #1 after
    // the output handshake edge, with the instance back in IDLE.
    task automatic run_txn(input int l, input logic [127:0] st, input logic dec,
                           input int stall, input logic [127:0] exp);
        int lat;
        check("idle_ready", 128'(in_ready_a[l]), 128'd1);
        in_valid_a[l]  = 1'b1;
        in_state_a[l]  = st;
        in_dec_a[l]    = dec;
        out_ready_a[l] = 1'b0;
        @(posedge clk); #1;
        // Inputs are scrambled after acceptance. They must not affect the result.
        in_valid_a[l]  = 1'($urandom_range(0, 1));
        in_state_a[l]  = rand128();
        in_dec_a[l]    = 1'($urandom_range(0, 1));
        out_ready_a[l] = (stall == 0);
        lat = 0;
        while (out_valid_a[l] !== 1'b1 && lat < 40) begin
            check("run_flags", {126'd0, in_ready_a[l], busy_a[l]}, 128'b01);
            @(posedge clk); #1;
            lat++;
            in_state_a[l] = rand128();
        end
        check("latency", 128'(lat), 128'(16 >> l));
        check("result", out_state_a[l], exp);
        for (int s = 0; s < stall; s++) begin
            in_valid_a[l] = 1'($urandom_range(0, 1));
            in_state_a[l] = rand128();
            in_dec_a[l]   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("hold_valid", 128'(out_valid_a[l]), 128'd1);
            check("hold_state", out_state_a[l], exp);
            check("hold_ready", 128'(in_ready_a[l]), 128'd0);
        end
        out_ready_a[l] = 1'b1;
        in_valid_a[l]  = 1'b1;   // offered at the handshake edge; must not be taken
        @(posedge clk); #1;
        check("hs_valid", 128'(out_valid_a[l]), 128'd0);
        check("hs_ready", 128'(in_ready_a[l]), 128'd1);
        check("hs_idle", 128'(busy_a[l]), 128'd0);
        check("retain", out_state_a[l], exp);
        out_ready_a[l] = 1'b0;
        in_valid_a[l]  = 1'b0;
    endtask

    initial begin
        logic [127:0] st;
        logic         dec;
        int           stall;

        build_tables();
        for (int l = 0; l < 3; l++) begin
            rst_n_a[l]     = 1'b0;
            in_valid_a[l]  = 1'b0;
            in_dec_a[l]    = 1'b0;
            in_state_a[l]  = '0;
            out_ready_a[l] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int l = 0; l < 3; l++) begin
            check("rst_ready", 128'(in_ready_a[l]), 128'd1);
            check("rst_valid", 128'(out_valid_a[l]), 128'd0);
            check("rst_busy", 128'(busy_a[l]), 128'd0);
            check("rst_state", out_state_a[l], 128'h0);
            rst_n_a[l] = 1'b1;
        end

        // Directed vectors on LANES=1.
        run_txn(0, 128'h0, 1'b0, 0, 128'h63636363_63636363_63636363_63636363);
        run_txn(0, 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, 1'b0, 2,
                128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
        run_txn(0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, 10,
                128'h193de3be_a0f4e22b_9ac68d2a_e9f84808);
        run_txn(1, 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, 1'b0, 1,
                128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
        run_txn(2, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, 0,
                128'h193de3be_a0f4e22b_9ac68d2a_e9f84808);

        // Abort by reset in the middle of RUN, then accept on the first edge after release.
        in_valid_a[0] = 1'b1;
        in_state_a[0] = rand128();
        in_dec_a[0]   = 1'b0;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("abort_run_valid", 128'(out_valid_a[0]), 128'd0);
            @(posedge clk); #1;
        end
        rst_n_a[0] = 1'b0;
        @(posedge clk); #1;
        rst_n_a[0] = 1'b1;
        check("abort_valid", 128'(out_valid_a[0]), 128'd0);
        check("abort_busy", 128'(busy_a[0]), 128'd0);
        check("abort_state", out_state_a[0], 128'h0);
        run_txn(0, 128'h0, 1'b1, 3, 128'h52525252_52525252_52525252_52525252);

        // Random states, modes and stalls on every lane configuration.
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 1000; i++) begin
                st    = rand128();
                dec   = 1'($urandom_range(0, 1));
                stall = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3));
                run_txn(l, st, dec, stall, ref_xform(st, dec));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
